// File: rtl/pc_unit.sv
// Fetch PC generator: priority redirect select, stall hold with one pending redirect, trap/epc.
// Latency: 1 cycle from request to new pc; stall freezes pc and defers the winning redirect.
// Optional misaligned-target trap enabled by PC_MISALIGN_TRAP_EN.
module pc_unit #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0]  TRAP_VEC  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap,
    input  logic            mret,
    input  logic            branch_taken,
    input  logic            jalr,
    input  logic            jal,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] jal_target,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc,
    output logic            redirect,
    output logic            misaligned
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD, HOLD_PEND} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pend, pend_n;
    logic            pend_mis, pend_mis_n;
    logic [XLEN-1:0] pc_n, epc_n;
    logic            redirect_n, misaligned_n;

    logic [XLEN-1:0] jalr_clr, raw_tgt, tgt, win_tgt, seq_pc;
    logic            tgt_req, tgt_mis, eff_trap, any_redir;

    always_comb begin
        jalr_clr = jalr_target & ~XLEN'(1);
        if (branch_taken)
            raw_tgt = branch_target;
        else if (jalr)
            raw_tgt = jalr_clr;
        else
            raw_tgt = jal_target;
        tgt_req = branch_taken | jalr | jal;
`ifdef PC_MISALIGN_TRAP_EN
        tgt     = raw_tgt;
        tgt_mis = tgt_req & (|raw_tgt[1:0]);
`else
        tgt     = raw_tgt & ~XLEN'(3);
        tgt_mis = 1'b0;
`endif
        // A misaligned target only matters when it actually wins over mret.
        eff_trap  = trap | (~mret & tgt_mis);
        any_redir = trap | mret | tgt_req;
        if (eff_trap)
            win_tgt = TRAP_VEC;
        else if (mret)
            win_tgt = epc;
        else
            win_tgt = tgt;
        seq_pc = pc + XLEN'(4);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= BOOT;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            BOOT:      state_n = RUN;
            RUN, HOLD: state_n = stall ? (any_redir ? HOLD_PEND : HOLD) : RUN;
            HOLD_PEND: state_n = stall ? HOLD_PEND : RUN;
            default:   state_n = BOOT;
        endcase
    end

    always_comb begin
        pc_valid = (state != BOOT);
    end

    always_comb begin
        pc_n         = pc;
        epc_n        = epc;
        pend_n       = pend;
        pend_mis_n   = pend_mis;
        redirect_n   = 1'b0;
        misaligned_n = 1'b0;
        case (state)
            RUN, HOLD: begin
                if (!stall) begin
                    if (any_redir) begin
                        pc_n         = win_tgt;
                        redirect_n   = 1'b1;
                        misaligned_n = eff_trap & ~trap;
                        if (eff_trap)
                            epc_n = pc;
                    end else begin
                        pc_n = seq_pc;
                    end
                end else if (any_redir) begin
                    pend_n     = win_tgt;
                    pend_mis_n = eff_trap & ~trap;
                    if (eff_trap)
                        epc_n = pc;
                end
            end
            HOLD_PEND: begin
                if (trap) begin
                    epc_n      = pc;
                    pend_mis_n = 1'b0;
                    if (stall) begin
                        pend_n = TRAP_VEC;
                    end else begin
                        pc_n       = TRAP_VEC;
                        redirect_n = 1'b1;
                        pend_n     = '0;
                    end
                end else if (!stall) begin
                    pc_n         = pend;
                    redirect_n   = 1'b1;
                    misaligned_n = pend_mis;
                    pend_n       = '0;
                    pend_mis_n   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_VEC;
            epc        <= '0;
            pend       <= '0;
            pend_mis   <= 1'b0;
            redirect   <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            pc         <= pc_n;
            epc        <= epc_n;
            pend       <= pend_n;
            pend_mis   <= pend_mis_n;
            redirect   <= redirect_n;
            misaligned <= misaligned_n;
        end
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and target width (>=8).
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, PC value after reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0100, PC loaded on trap.
REQ-004 SHALL have ports: clk  in  1  clock; single clock domain, rising edge.
REQ-005 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: stall  in  1  hold PC this cycle.
REQ-007 SHALL have ports: trap  in  1  exception request.
REQ-008 SHALL have ports: mret  in  1  return from trap.
REQ-009 SHALL have ports: branch_taken / jalr / jal  in  1 each  redirect requests.
REQ-010 SHALL have ports: branch_target / jalr_target / jal_target  in  XLEN each  redirect targets.
REQ-011 SHALL have ports: pc  out  XLEN  current fetch PC.
REQ-012 SHALL have ports: pc_valid  out  1  pc is a real fetch address.
REQ-013 SHALL have ports: epc  out  XLEN  saved exception PC.
REQ-014 SHALL have ports: redirect  out  1  PC just loaded non-sequentially (flush hint).
REQ-015 SHALL have ports: misaligned  out  1  misaligned-target trap taken.

Function
REQ-016 SHALL select next source by priority: trap > mret > branch_taken > jalr > jal > pc+4.
REQ-017 SHALL clear bit 0 of jalr_target before use.
REQ-018 SHALL compute pc+4 modulo 2^XLEN; all-ones-minus-3 wraps to 0.
REQ-019 SHALL implement FSM states BOOT, RUN, HOLD, HOLD_PEND.
REQ-020 BOOT: pc=RESET_VEC, pc_valid=0; always to RUN next cycle; inputs ignored.
REQ-021 RUN, stall=0: pc<=selected source; redirect<=1 iff source not pc+4; pc_valid=1.
REQ-022 RUN, stall=1, no redirect input: pc held; go HOLD.
REQ-023 RUN or HOLD, stall=1, any redirect input: pc held; winning target latched in pending register; go HOLD_PEND.
REQ-024 HOLD_PEND, stall=1: trap input replaces pending with TRAP_VEC (epc captured per REQ-027); lower-priority inputs ignored.
REQ-025 HOLD or HOLD_PEND, stall=0: HOLD behaves as RUN; HOLD_PEND loads pending (trap input this cycle overrides), redirect<=1, clears pending; go RUN.
REQ-026 mret: pc<=epc.
REQ-027 trap: pc<=TRAP_VEC; epc<=pc current value; trap during BOOT ignored.
REQ-028 redirect and misaligned SHALL be 1-cycle registered pulses aligned with the new pc.
REQ-029 pc_valid SHALL stay 1 while stalled after BOOT.

Reset
REQ-030 rst=1 at clock edge SHALL force pc=RESET_VEC, epc=0, pending=0, pc_valid=0, redirect=0, misaligned=0, state BOOT.
REQ-031 rst SHALL override all inputs including stall and trap; pending redirect dropped on reset mid-stall.
REQ-032 No asynchronous reset path SHALL exist.

Configuration
REQ-033 Macro PC_MISALIGN_TRAP_EN SHALL enable misaligned-target detection.
REQ-034 Defined: branch/jalr/jal target with bits[1:0]!=0 (after REQ-017) SHALL be replaced by trap behaviour: pc<=TRAP_VEC, epc<=pc, misaligned pulse 1; applies also to pending targets at latch time.
REQ-035 Undefined: targets SHALL be used with bits[1:0] forced to 00; misaligned tied 0.

Verification
REQ-036 Reset release: rst 1->0 -> cycle1 pc=0 pc_valid=0; cycle2 pc=0 pc_valid=1; cycle3 pc=4.
REQ-037 Priority: branch_taken=1 (0x200), jalr=1 (0x301), jal=1 (0x400) same cycle -> pc=0x200, redirect=1; jalr only -> pc=0x300.
REQ-038 Stall pending: pc=0x10, stall=1 three cycles, jal=1 target 0x80 in first -> pc stays 0x10; stall=0 -> pc=0x80, redirect=1, then 0x84.
REQ-039 Trap/mret: pc=0x44, trap=1 -> pc=0x100, epc=0x44; later mret=1 -> pc=0x44.
REQ-040 Wrap/misaligned: pc=0xFFFF_FFFC -> next pc=0; with PC_MISALIGN_TRAP_EN branch to 0x202 -> pc=0x100, misaligned=1; without -> pc=0x200, misaligned=0.
